// File: rtl/random_pkg.sv
// Shared types for the random word dispenser: FSM state encoding and the
// pointer/counter width helper.
package random_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    FILL   = 2'd2
  } state_e;

  // Bits needed to index n entries; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/random_word_fifo.sv
// First-word-fall-through FIFO for captured random words. Pointers and level
// are reset; the storage array is not.
module random_word_fifo
  import random_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Width-1:0]       wdata,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] level
);

  localparam int PW = ptr_width(Depth);
  localparam logic [PW:0]   LvlFull = (PW+1)'(Depth);
  localparam logic [PW:0]   LvlOne  = (PW+1)'(1);
  localparam logic [PW-1:0] PtrOne  = PW'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full  = (level_q == LvlFull);
  assign empty = (level_q == {(PW+1){1'b0}});
  assign level = level_q;
  assign rdata = empty ? {Width{1'b0}} : mem_q[rd_ptr_q];

  // Next pointers and occupancy; requests against full/empty are dropped.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = push_ok ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    rd_ptr_d = pop_ok ? (rd_ptr_q + PtrOne) : rd_ptr_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + LvlOne;
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LvlOne;
    end else begin
      level_d = level_q;
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {(PW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Word storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/random_word_dispenser.sv
// Steps a cellular-automaton generator, buffers its words in a FWFT FIFO for
// GA operators, and flags a generator that keeps repeating the same word.
module random_word_dispenser
  import random_pkg::*;
#(
  parameter int Width       = 32,
  parameter int Depth       = 8,
  parameter int WarmupSteps = 4,
  parameter int RepeatLimit = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   gen_ce,
  input  logic [Width-1:0]       gen_word,
  output logic                   rd_valid,
  output logic [Width-1:0]       rd_data,
  input  logic                   rd_ready,
  output logic [$clog2(Depth):0] level,
  output logic                   stuck_err
);

  localparam int CW = ptr_width(WarmupSteps);
  localparam int RW = ptr_width(RepeatLimit);
  localparam logic [CW-1:0] StepLast = CW'(WarmupSteps - 1);
  localparam logic [CW-1:0] StepOne  = CW'(1);
  localparam logic [RW-1:0] RptMax   = RW'(RepeatLimit - 1);
  localparam logic [RW-1:0] RptOne   = RW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    step_q, step_d;
  logic [Width-1:0] prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic [RW-1:0]    rpt_q, rpt_d;
  logic             stuck_q, stuck_d;
  logic             full_s, empty_s, push_s, pop_s;

  assign push_s    = (state_q == FILL) & gen_ce;
  assign rd_valid  = ~empty_s;
  assign pop_s     = rd_valid & rd_ready;
  assign stuck_err = stuck_q;

  // Sequencer: one idle cycle, WarmupSteps discarded steps, then fill forever.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    gen_ce  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = WARMUP;
      end
      WARMUP: begin
        gen_ce = 1'b1;
        if (step_q == StepLast) begin
          state_d = FILL;
        end else begin
          step_d = step_q + StepOne;
        end
      end
      FILL: begin
        gen_ce = ~full_s;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Repeat detector, advanced only by words that actually enter the FIFO.
  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    rpt_d      = rpt_q;
    stuck_d    = stuck_q;
    if (push_s) begin
      prev_d     = gen_word;
      prev_vld_d = 1'b1;
      if (!prev_vld_q) begin
        rpt_d = {RW{1'b0}};
      end else if (gen_word == prev_q) begin
        rpt_d = (rpt_q == RptMax) ? rpt_q : (rpt_q + RptOne);
      end else begin
        rpt_d = {RW{1'b0}};
      end
      stuck_d = stuck_q | (rpt_d == RptMax);
    end else begin
      stuck_d = stuck_q;
    end
  end

  // Control and detector registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= {CW{1'b0}};
      prev_q     <= {Width{1'b0}};
      prev_vld_q <= 1'b0;
      rpt_q      <= {RW{1'b0}};
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      rpt_q      <= rpt_d;
      stuck_q    <= stuck_d;
    end
  end

  random_word_fifo #(
    .Width (Width),
    .Depth (Depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (gen_word),
    .rdata (rd_data),
    .full  (full_s),
    .empty (empty_s),
    .level (level)
  );

endmodule

// File: tb/tb_random_word_dispenser.sv
// Scoreboard bench for random_word_dispenser driving an 8-bit LFSR generator.
module tb_random_word_dispenser;

  localparam int Width       = 8;
  localparam int Depth       = 4;
  localparam int WarmupSteps = 2;
  localparam int RepeatLimit = 3;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       rd_ready  = 1'b0;
  logic       force_en  = 1'b0;
  logic [7:0] force_val = 8'h00;
  logic [7:0] lfsr_q    = 8'h01;
  logic       gen_ce, rd_valid, stuck_err;
  logic [7:0] gen_word, rd_data;
  logic [2:0] level;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb[$];

  random_word_dispenser #(
    .Width       (Width),
    .Depth       (Depth),
    .WarmupSteps (WarmupSteps),
    .RepeatLimit (RepeatLimit)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gen_ce    (gen_ce),
    .gen_word  (gen_word),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .level     (level),
    .stuck_err (stuck_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Generator model: steps only when enabled, never reset by the dispenser.
  always @(posedge clk) begin
    if (gen_ce) lfsr_q <= lfsr_step(lfsr_q);
  end
  assign gen_word = force_en ? force_val : lfsr_q;

  // Entered at a negedge with rst=1; releases reset and walks the warm-up.
  task automatic test_warmup(input string tag);
    logic [7:0] w;
    checks++;
    if (gen_ce !== 1'b0 || rd_valid !== 1'b0 || level !== 3'd0 || stuck_err !== 1'b0 || rd_data !== 8'h00) begin
      failures++;
      $display("FAIL %s_reset_state: got ce=%b vld=%b lvl=%0d stuck=%b data=%h, want all 0", tag, gen_ce, rd_valid, level, stuck_err, rd_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (gen_ce !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_ce: got %b want 0", tag, gen_ce);
    end
    sb.delete();
    w = lfsr_q;
    repeat (WarmupSteps) w = lfsr_step(w);
    repeat (40) begin
      sb.push_back(w);
      w = lfsr_step(w);
    end
    for (int c = 0; c < WarmupSteps; c++) begin
      @(negedge clk);
      checks++;
      if (gen_ce !== 1'b1 || level !== 3'd0 || rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_warmup%0d: got ce=%b lvl=%0d vld=%b want ce=1 lvl=0 vld=0", tag, c, gen_ce, level, rd_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (gen_ce !== 1'b1 || level !== 3'd0) begin
      failures++;
      $display("FAIL %s_fill_entry: got ce=%b lvl=%0d want ce=1 lvl=0", tag, gen_ce, level);
    end
  endtask

  task automatic test_fill_hold();
    logic [7:0] frozen;
    for (int i = 0; i < Depth; i++) begin
      @(negedge clk);
      checks++;
      if (level !== 3'(i + 1) || rd_valid !== 1'b1 || rd_data !== sb[0]) begin
        failures++;
        $display("FAIL fill_level%0d: got lvl=%0d vld=%b data=%h want lvl=%0d vld=1 data=%h", i, level, rd_valid, rd_data, i + 1, sb[0]);
      end
    end
    frozen = lfsr_q;
    repeat (3) @(negedge clk);
    checks++;
    if (gen_ce !== 1'b0 || level !== 3'd4 || lfsr_q !== frozen) begin
      failures++;
      $display("FAIL full_frozen: got ce=%b lvl=%0d gen=%h want ce=0 lvl=4 gen=%h", gen_ce, level, lfsr_q, frozen);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp;
    rd_ready = 1'b1;
    #1;
    exp = sb.pop_front();
    checks++;
    if (gen_ce !== 1'b0 || rd_data !== exp) begin
      failures++;
      $display("FAIL full_pop_head: got ce=%b data=%h want ce=0 data=%h", gen_ce, rd_data, exp);
    end
    @(negedge clk);
    rd_ready = 1'b0;
    checks++;
    if (level !== 3'd3 || gen_ce !== 1'b1 || rd_data !== sb[0]) begin
      failures++;
      $display("FAIL after_pop: got lvl=%0d ce=%b data=%h want lvl=3 ce=1 data=%h", level, gen_ce, rd_data, sb[0]);
    end
    @(negedge clk);
    checks++;
    if (level !== 3'd4 || gen_ce !== 1'b0) begin
      failures++;
      $display("FAIL refill: got lvl=%0d ce=%b want lvl=4 ce=0", level, gen_ce);
    end
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp = sb.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        failures++;
        $display("FAIL drain_w%0d: got vld=%b data=%h want vld=1 data=%h", i, rd_valid, rd_data, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    checks++;
    if (level !== 3'd3) begin
      failures++;
      $display("FAIL pre_reset_level: got %0d want 3", level);
    end
    rd_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || level !== 3'd0 || gen_ce !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got vld=%b lvl=%0d ce=%b want 0 0 0", rd_valid, level, gen_ce);
    end
    @(negedge clk);
    test_warmup("mid");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checks++;
      if (level !== 3'(i)) begin
        failures++;
        $display("FAIL b2b_prefill%0d: got lvl=%0d want %0d", i, level, i);
      end
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp = sb.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        failures++;
        $display("FAIL b2b_word%0d: got vld=%b data=%h want vld=1 data=%h", i, rd_valid, rd_data, exp);
      end
      @(negedge clk);
      checks++;
      if (level !== 3'd2) begin
        failures++;
        $display("FAIL b2b_level%0d: got %0d want 2", i, level);
      end
    end
  endtask

  task automatic test_stuck();
    force_en  = 1'b1;
    force_val = 8'h5A;
    @(negedge clk);
    force_val = 8'hA5;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (stuck_err !== (k == 3)) begin
        failures++;
        $display("FAIL stuck_after_a5_%0d: got %b want %b", k, stuck_err, (k == 3));
      end
    end
    force_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (stuck_err !== 1'b1 || level !== 3'd2) begin
      failures++;
      $display("FAIL stuck_sticky: got stuck=%b lvl=%0d want stuck=1 lvl=2", stuck_err, level);
    end
    rd_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (stuck_err !== 1'b0) begin
      failures++;
      $display("FAIL stuck_rst_clear: got %b want 0", stuck_err);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_warmup("por");
    test_fill_hold();
    test_full_pop();
    test_reset_mid();
    test_back_to_back();
    test_stuck();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/random_word_dispenser.md
# random_word_dispenser

Buffered consumer side of the cellular-automaton random generators. The block steps an attached generator through its `ce` input and captures each word into a small FIFO. It then serves those words to GA operators (mutation, crossover, selection) over a valid/ready read port. It also runs a warm-up sequence after reset and raises a sticky health flag when the generator output repeats.

## Interface
Parameters:
- `Width`, 32, random word width; must match the generator output width.
- `Depth`, 8, FIFO depth in words; power of two, ≥2.
- `WarmupSteps`, 4, generator steps discarded after reset; ≥1.
- `RepeatLimit`, 4, consecutive identical captured words that set `stuck_err`; ≥2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `gen_ce`  out  1  step enable to the generator's `ce`.
- `gen_word`  in  Width  current generator output. It is combinational from generator state and changes after each edge where `gen_ce`=1.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_data`  out  Width  head word (first-word-fall-through).
- `rd_ready`  in  1  consumer accepts the head word.
- `level`  out  $clog2(Depth)+1  FIFO occupancy.
- `stuck_err`  out  1  sticky repeat-fault flag.

## Operation
FSM states and transitions:
- IDLE is the reset state. It moves to WARMUP unconditionally on the next edge. `gen_ce`=0.
- WARMUP: `gen_ce`=1. A step counter increments on each edge. On the edge where the counter reaches `WarmupSteps`-1, the FSM moves to FILL. No pushes occur in this state.
- FILL is terminal until `rst`. `gen_ce` = !full, where full means `level`==`Depth`.

`gen_ce` is combinational from the registered state and `level` only. It never depends on `rd_ready`.

Push:
- In FILL, every edge with `gen_ce`=1 writes the present `gen_word` into the FIFO.
- The same edge advances the generator. The sampled word is therefore the one produced by the previous step.

Pop:
- Occurs on an edge with `rd_valid` & `rd_ready`.
- `rd_ready` while empty is ignored.

`level` update rules:
- push only: +1.
- pop only: −1.
- both in the same edge: unchanged.
- When full, a pop frees a slot, but no push occurs in that same cycle. The push resumes on the next cycle.

Ordering: strict FIFO. Read and write pointers are $clog2(Depth) bits and wrap modulo `Depth`.

Stuck detector:
- `prev` (Width bits) and `prev_vld` are updated on pushes only.
- First push after reset: loads `prev`, sets `prev_vld`, `rpt`=0.
- Later pushes: if `gen_word`==`prev`, `rpt`=min(`rpt`+1, `RepeatLimit`-1); otherwise `rpt`=0. `prev` is loaded with `gen_word` on every push.
- `stuck_err` is set on the edge where `rpt` becomes `RepeatLimit`-1, i.e. on the `RepeatLimit`-th identical word in a row.
- `stuck_err` is cleared only by `rst`. Pushes continue while it is set.

## Timing
Reset values (asynchronous):
- state=IDLE.
- `gen_ce`=0, `rd_valid`=0, `rd_data`=0, `level`=0, `stuck_err`=0.
- Pointers, `rpt`, `prev`, `prev_vld` all cleared.

Latency:
- First push occurs on edge 1+`WarmupSteps`+1 after reset release (1 IDLE cycle, then `WarmupSteps` warm-up cycles).
- A word pushed at edge k is on `rd_data` with `rd_valid`=1 during cycle k+1.
- A pop at edge k presents the next word in cycle k+1.

Throughput: one word per cycle sustained when not full. When a full FIFO is drained, throughput has a one-cycle bubble.

Reset mid-operation: all contents are discarded immediately and the sequence restarts from IDLE. Generator state is not reset by this block.

## Structure
- A shared package `random_pkg` holds:
  - the FSM state enum: IDLE, WARMUP, FILL;
  - the pointer/level width function.
- One sub-module, `random_word_fifo`:
  - parameterized `Width` and `Depth`;
  - interface: push, pop, full, empty, `level`, FWFT data;
  - behaviour: asynchronous reset clears pointers and `level`; memory contents are not reset.
- The FSM, warm-up counter and stuck detector live in the top level.

## Test plan
Bench parameters: `Width`=8, `Depth`=4, `WarmupSteps`=2, `RepeatLimit`=3. The generator model is an 8-bit LFSR stepped by `gen_ce`.

- Reset release with `rd_ready`=0 → `gen_ce` pattern is 0 for 1 cycle, then 1 for 2 cycles (no push, `level`=0), then pushes start.
- Hold `rd_ready`=0 → words W0..W3 are captured, `level`=4, `gen_ce`=0 thereafter, and the generator is frozen.
- Full, then `rd_ready`=1 for one cycle → W0 is popped and `level`=3. The next cycle pushes W4 and `level` returns to 4. `rd_data` order is W1, W2, W3, W4.
- `level`=2 with `rd_ready` held 1 → `level` stays 2. Output words match generator order with no loss or duplication across pointer wrap (≥10 words).
- `gen_word` forced to 0xA5 → `stuck_err` rises on the edge of the 3rd consecutive 0xA5 push. It stays 1 after `gen_word` changes and clears only on `rst`.
- `rst` pulse mid-cycle with `level`=3 → `rd_valid`=0, `level`=0 and `gen_ce`=0 immediately. After release the full warm-up sequence repeats.
